stream_frame_sequencer: RTL

STREAM_FRAME_SEQUENCER -- requirements
Module: stream_frame_sequencer

---
 rtl/seq_pkg.sv | 15 +
 rtl/stream_frame_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the stream frame sequencer.
package seq_pkg;

    // Width of the completed-frame counter.
    localparam int FRAME_CNT_W = 16;

    // Sequencer states: idle, issuing pixels, line blanking, frame blanking.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } seq_state_t;

endpackage

// File: rtl/stream_frame_sequencer.sv
// Raster frame sequencer: issues one pixel read per accepted cycle across
// IMG_WIDTH x IMG_HEIGHT, inserting line and frame blanking, with
// single-shot or continuous operation and a graceful stop request.
module stream_frame_sequencer
    import seq_pkg::*;
#(
    parameter int IMG_WIDTH  = 2560,
    parameter int IMG_HEIGHT = 1440,
    parameter int H_BLANK    = 20,
    parameter int V_BLANK    = 4,
    parameter int CNT_W      = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   continuous,
    input  logic                   src_ready,
    output logic                   read_en,
    output logic                   sof,
    output logic                   eol,
    output logic                   eof,
    output logic                   busy,
    output logic                   frame_done,
    output logic [CNT_W-1:0]       x_cnt,
    output logic [CNT_W-1:0]       y_cnt,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] X_LAST  = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] VB_LAST = CNT_W'(V_BLANK - 1);
    // Blanking count one cycle before the last VBLANK cycle; only used when V_BLANK > 1.
    localparam logic [CNT_W-1:0] VB_PRE  = CNT_W'(V_BLANK - 2);

    seq_state_t state;
    logic       stop_pending;

    // Pixel strobes decoded from state and counters; read_en follows src_ready with no delay.
    always_comb begin
        read_en = (state == ACTIVE) && src_ready;
        sof     = read_en && (x_cnt == '0) && (y_cnt == '0);
        eol     = read_en && (x_cnt == X_LAST);
        eof     = eol && (y_cnt == Y_LAST);
        busy    = (state != IDLE);
    end

    // Sequencer FSM with counters, stop latch and registered frame_done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            x_cnt        <= '0;
            y_cnt        <= '0;
            frame_cnt    <= '0;
            stop_pending <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (stop) begin
                stop_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ACTIVE;
                        x_cnt <= '0;
                        y_cnt <= '0;
                    end
                end

                ACTIVE: begin
                    if (src_ready) begin
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            if (y_cnt == Y_LAST) begin
                                y_cnt <= '0;
                                state <= VBLANK;
                                // A one-cycle VBLANK is itself the last blanking cycle.
                                if (V_BLANK == 1) begin
                                    frame_done <= 1'b1;
                                end
                            end else begin
                                state <= HBLANK;
                            end
                        end else begin
                            x_cnt <= x_cnt + CNT_W'(1);
                        end
                    end
                end

                HBLANK: begin
                    if (x_cnt == HB_LAST) begin
                        x_cnt <= '0;
                        y_cnt <= y_cnt + CNT_W'(1);
                        state <= ACTIVE;
                    end else begin
                        x_cnt <= x_cnt + CNT_W'(1);
                    end
                end

                VBLANK: begin
                    if (x_cnt == VB_LAST) begin
                        x_cnt     <= '0;
                        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                        if (continuous && !stop_pending && !stop) begin
                            state <= ACTIVE;
                        end else begin
                            state        <= IDLE;
                            stop_pending <= 1'b0;
                        end
                    end else begin
                        x_cnt <= x_cnt + CNT_W'(1);
                        // Raise frame_done so it is visible during the last blanking cycle.
                        if ((V_BLANK > 1) && (x_cnt == VB_PRE)) begin
                            frame_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
